// File: rtl/lowampa_pkg.sv
// Shared types and beat packing for the lowampa synthetic ADC stream source.
// Optional noise helpers exist only when PATTERN_NOISE_EN is defined.
package lowampa_pkg;

    localparam int SAMPLE_BITS = 12;
    localparam int PAD_BITS    = 4;
    localparam int NSAMP       = 4;
    localparam int LANE_BITS   = SAMPLE_BITS + PAD_BITS;
    localparam int BEAT_BITS   = NSAMP * SAMPLE_BITS;
    localparam int TDATA_BITS  = NSAMP * LANE_BITS;

    typedef logic signed [SAMPLE_BITS-1:0] sample_t;
    typedef sample_t [NSAMP-1:0] beat_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic logic [TDATA_BITS-1:0] pack_beat(input beat_t b);
        logic [TDATA_BITS-1:0] d;
        d = '0;
        for (int i = 0; i < NSAMP; i++)
            d[LANE_BITS*i+PAD_BITS +: SAMPLE_BITS] = b[i];
        return d;
    endfunction

    function automatic beat_t unpack_beat(input logic [TDATA_BITS-1:0] d);
        beat_t b;
        for (int i = 0; i < NSAMP; i++)
            b[i] = d[LANE_BITS*i+PAD_BITS +: SAMPLE_BITS];
        return b;
    endfunction

`ifdef PATTERN_NOISE_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Galois form, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic beat_t add_noise(input beat_t b, input logic [15:0] l);
        beat_t                        r;
        logic signed [SAMPLE_BITS:0]  s;
        logic        [3:0]            n;
        for (int i = 0; i < NSAMP; i++) begin
            n = l[4*i +: 4];
            s = {b[i][SAMPLE_BITS-1], b[i]} + {{(SAMPLE_BITS-3){n[3]}}, n};
            // Top two bits disagree only on overflow; clamp toward the sign.
            if (s[SAMPLE_BITS] != s[SAMPLE_BITS-1])
                r[i] = s[SAMPLE_BITS] ? {1'b1, {(SAMPLE_BITS-1){1'b0}}}
                                      : {1'b0, {(SAMPLE_BITS-1){1'b1}}};
            else
                r[i] = s[SAMPLE_BITS-1:0];
        end
        return r;
    endfunction
`endif

endpackage

// File: rtl/lowampa_skid_buffer.sv
// Two-entry valid/ready FIFO that absorbs the RAM read latency under backpressure.
module lowampa_skid_buffer #(
    parameter int W = 8
) (
    input  logic         aclk,
    input  logic         reset_i,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   occupancy
);

    logic [1:0][W-1:0] mem;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              push;
    logic              pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign occupancy = count;
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && ((count != 2'd2) || pop);

    always_ff @(posedge aclk) begin
        if (reset_i) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lowampa_stream_source.sv
// Replays a pattern RAM as a 64-bit AXI4-Stream of 4 padded 12-bit samples.
// Define PATTERN_NOISE_EN to add saturated LFSR noise at the output.
module lowampa_stream_source
    import lowampa_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  aclk,
    input  logic                  reset_i,
    input  logic                  cfg_we,
    input  logic [DEPTH_LOG2-1:0] cfg_addr,
    input  logic [BEAT_BITS-1:0]  cfg_wdata,
    input  logic [DEPTH_LOG2-1:0] cfg_len,
    input  logic                  cfg_mode,
    input  logic                  start_i,
    input  logic                  stop_i,
    output logic [TDATA_BITS-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  busy_o,
    output logic                  wrap_o,
    output logic                  done_o,
    output logic [31:0]           beat_count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SB_W  = BEAT_BITS + DEPTH_LOG2;

    logic [BEAT_BITS-1:0]  ram [DEPTH];
    state_t                state;
    state_t                state_nxt;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] len_q;
    logic                  mode_q;
    logic [BEAT_BITS-1:0]  rd_data;
    logic                  rd_vld;
    logic                  rd_en;
    logic                  pop;
    logic                  start_go;
    logic [1:0]            occ;
    logic [2:0]            fill_nxt;
    logic [SB_W-1:0]       sb_dout;
    logic [DEPTH_LOG2-1:0] sb_idx;
    beat_t                 head;
    beat_t                 beat_out;

    assign pop      = m_tvalid && m_tready;
    assign start_go = (state == IDLE) && (state_nxt == RUN);
    // Entries held after this cycle, counting the read already in flight.
    assign fill_nxt = {1'b0, occ} - {2'b0, pop} + {2'b0, rd_vld};

    always_ff @(posedge aclk) begin
        if (reset_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i && !stop_i) state_nxt = RUN;
            RUN:     if (stop_i || (rd_en && (rd_ptr == len_q) && !mode_q)) state_nxt = DRAIN;
            DRAIN:   if (fill_nxt == 3'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_en  = (state == RUN) && !stop_i && (fill_nxt < 3'd2);
        busy_o = (state != IDLE);
    end

    // Read-first: a same-address write lands after this read samples.
    always_ff @(posedge aclk) begin
        if (cfg_we)
            ram[cfg_addr] <= cfg_wdata;
        if (rd_en) begin
            rd_data <= ram[rd_ptr];
            rd_idx  <= rd_ptr;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset_i) begin
            rd_ptr       <= '0;
            len_q        <= '0;
            mode_q       <= 1'b0;
            rd_vld       <= 1'b0;
            beat_count_o <= '0;
            wrap_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            wrap_o <= pop && (sb_idx == len_q);
            done_o <= (state == DRAIN) && (state_nxt == IDLE);
            if (start_go) begin
                len_q        <= cfg_len;
                mode_q       <= cfg_mode;
                rd_ptr       <= '0;
                beat_count_o <= '0;
            end else begin
                if (pop)
                    beat_count_o <= beat_count_o + 32'd1;
                if (rd_en)
                    rd_ptr <= (rd_ptr == len_q) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    lowampa_skid_buffer #(.W(SB_W)) u_skid (
        .aclk      (aclk),
        .reset_i   (reset_i),
        .in_valid  (rd_vld),
        .in_data   ({rd_idx, rd_data}),
        .out_valid (m_tvalid),
        .out_data  (sb_dout),
        .out_ready (m_tready),
        .occupancy (occ)
    );

    assign sb_idx = sb_dout[SB_W-1 -: DEPTH_LOG2];
    assign head   = sb_dout[BEAT_BITS-1:0];

`ifdef PATTERN_NOISE_EN
    logic [15:0] lfsr;

    always_ff @(posedge aclk) begin
        if (reset_i || start_go)
            lfsr <= LFSR_SEED;
        else if (pop)
            lfsr <= lfsr_next(lfsr);
    end

    assign beat_out = add_noise(head, lfsr);
`else
    assign beat_out = head;
`endif

    // Zero when idle so stale buffer contents never show on the bus.
    assign m_tdata = m_tvalid ? pack_beat(beat_out) : '0;

endmodule

// File: tb/tb_lowampa_stream_source.sv
// Directed bench for lowampa_stream_source with a per-cycle stream model.
module tb_lowampa_stream_source;

    logic        aclk = 1'b0;
    logic        reset_i = 1'b1;
    logic        cfg_we = 1'b0;
    logic [8:0]  cfg_addr = '0;
    logic [47:0] cfg_wdata = '0;
    logic [8:0]  cfg_len = '0;
    logic        cfg_mode = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        busy_o;
    logic        wrap_o;
    logic        done_o;
    logic [31:0] beat_count_o;

    always #5 aclk = ~aclk;

    lowampa_stream_source dut (
        .aclk         (aclk),
        .reset_i      (reset_i),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_len      (cfg_len),
        .cfg_mode     (cfg_mode),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .busy_o       (busy_o),
        .wrap_o       (wrap_o),
        .done_o       (done_o),
        .beat_count_o (beat_count_o)
    );

    int          checks = 0;
    int          errors = 0;
    logic [47:0] mem_m [0:511];
    int          m_len = 0;
    bit          m_mode = 1'b0;
    int          acc_cnt = 0;
    bit          wrap_exp = 1'b0;
    bit          model_en = 1'b0;
    bit          stall_prev = 1'b0;
    logic [63:0] tdata_prev = '0;
    int          done_cnt = 0;
    int          wrap_cnt = 0;
    int          idx;
`ifdef PATTERN_NOISE_EN
    logic [15:0] m_lfsr = 16'hACE1;
`endif

    localparam logic [47:0] NEW0  = {12'h800, 12'h7FF, 12'h123, 12'hABC};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected bus word for a raw pattern beat at the current model noise state.
    function automatic logic [63:0] exp_beat(input logic [47:0] raw);
        logic [63:0]        d;
        logic signed [11:0] smp;
`ifdef PATTERN_NOISE_EN
        int                 s;
        logic signed [3:0]  n;
`endif
        d = '0;
        for (int i = 0; i < 4; i++) begin
            smp = raw[12*i +: 12];
`ifdef PATTERN_NOISE_EN
            n = m_lfsr[4*i +: 4];
            s = int'(smp) + int'(n);
            if (s > 2047) s = 2047;
            if (s < -2048) s = -2048;
            smp = 12'(s);
`endif
            d[16*i+4 +: 12] = smp;
        end
        return d;
    endfunction

    always @(negedge aclk) begin
        if (model_en && !reset_i) begin
            chk("beat_count", 64'(beat_count_o), 64'(acc_cnt));
            chk("wrap", 64'(wrap_o), 64'(wrap_exp));
            if (stall_prev) begin
                chk("hold_valid", 64'(m_tvalid), 64'd1);
                chk("hold_data", m_tdata, tdata_prev);
            end
            if (done_o) done_cnt++;
            if (wrap_o) wrap_cnt++;
            wrap_exp = 1'b0;
            if (m_tvalid && m_tready) begin
                idx = acc_cnt % (m_len + 1);
                if (!m_mode) chk("oneshot_extra", 64'(acc_cnt <= m_len), 64'd1);
                chk("tdata", m_tdata, exp_beat(mem_m[idx]));
                wrap_exp = (idx == m_len);
                acc_cnt++;
`ifdef PATTERN_NOISE_EN
                m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
`endif
            end
            stall_prev = m_tvalid && !m_tready;
            tdata_prev = m_tdata;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wr(input int a, input logic [47:0] d);
        cfg_we = 1'b1; cfg_addr = 9'(a); cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic start(input int len, input bit mode);
        cfg_len = 9'(len); cfg_mode = mode; start_i = 1'b1;
        @(posedge aclk);
        acc_cnt = 0; m_len = len; m_mode = mode; done_cnt = 0; wrap_cnt = 0;
`ifdef PATTERN_NOISE_EN
        m_lfsr = 16'hACE1;
`endif
        #1 start_i = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!m_tvalid && n < budget) begin tick(); n++; end
        chk("wait_valid", 64'(m_tvalid), 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy_o && n < budget) begin tick(); n++; end
        chk("wait_idle", 64'(busy_o), 64'd0);
    endtask

    task automatic stop_and_drain();
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        m_tready = 1'b1;
        wait_idle(20);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_i = 1'b1;
        repeat (3) tick();
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tdata", m_tdata, 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_wrap", 64'(wrap_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_count", 64'(beat_count_o), 64'd0);
        reset_i = 1'b0;
        for (int b = 0; b < 8; b++)
            wr(b, {12'(16*b+3), 12'(16*b+2), 12'(16*b+1), 12'(16*b)});
        model_en = 1'b1;

        // 1: one-shot len 3, latency and completion
        m_tready = 1'b1;
        start(3, 1'b0);
        chk("lat_e0", 64'(m_tvalid), 64'd0);
        tick();
        chk("lat_e1", 64'(m_tvalid), 64'd0);
        tick();
        chk("lat_e2", 64'(m_tvalid), 64'd1);
`ifndef PATTERN_NOISE_EN
        chk("beat0_lit", m_tdata, 64'h0030_0020_0010_0000);
`endif
        wait_idle(20);
        tick();
        chk("t1_count", 64'(beat_count_o), 64'd4);
        chk("t1_wraps", 64'(wrap_cnt), 64'd1);
        chk("t1_dones", 64'(done_cnt), 64'd1);
        repeat (3) tick();
        chk("t1_quiet", 64'(m_tvalid), 64'd0);
        chk("t1_busy", 64'(busy_o), 64'd0);

        // 2: loop len 1 at full rate
        start(1, 1'b1);
        wait_valid(5);
        for (int k = 0; k < 10; k++) begin
            chk("t2_no_bubble", 64'(m_tvalid), 64'd1);
            tick();
        end
        tick();
        chk("t2_wraps", 64'(wrap_cnt), 64'd5);
        stop_and_drain();
        chk("t2_dones", 64'(done_cnt), 64'd1);

        // 3: loop len 7 with sparse tready
        start(7, 1'b1);
        for (int k = 0; k < 2000; k++) begin
            m_tready = ($urandom_range(0, 99) < 30);
            tick();
        end
        stop_and_drain();
        chk("t3_count", 64'(beat_count_o), 64'(acc_cnt));
        chk("t3_dones", 64'(done_cnt), 64'd1);

        // 4: stop while stalled with two beats buffered
        m_tready = 1'b0;
        start(7, 1'b1);
        repeat (5) tick();
        chk("t4_stalled", 64'(m_tvalid), 64'd1);
        stop_and_drain();
        chk("t4_beats", 64'(acc_cnt), 64'd2);
        chk("t4_dones", 64'(done_cnt), 64'd1);
        start_i = 1'b1; stop_i = 1'b1;
        tick();
        start_i = 1'b0; stop_i = 1'b0;
        repeat (2) tick();
        chk("t4_ss_busy", 64'(busy_o), 64'd0);
        chk("t4_ss_valid", 64'(m_tvalid), 64'd0);

        // 5: write address 0 in the cycle it is read
        m_tready = 1'b1;
        start(1, 1'b1);
        wait_valid(5);
        tick(); tick();
        n = 0;
        while (!(m_tvalid && (acc_cnt % 2 == 0)) && n < 10) begin tick(); n++; end
        cfg_we = 1'b1; cfg_addr = 9'd0; cfg_wdata = NEW0;
        tick();
        cfg_we = 1'b0;
        tick();
`ifndef PATTERN_NOISE_EN
        chk("t5_old", m_tdata, 64'h0030_0020_0010_0000);
`endif
        tick();
        mem_m[0] = NEW0;
        tick();
`ifndef PATTERN_NOISE_EN
        chk("t5_new", m_tdata, 64'h8000_7FF0_1230_ABC0);
`endif
        stop_and_drain();

        // 6: reset mid-run, then restart from beat 0
        start(7, 1'b1);
        wait_valid(5);
        repeat (3) tick();
        chk("t6_pre_valid", 64'(m_tvalid), 64'd1);
        model_en = 1'b0;
        reset_i = 1'b1;
        tick();
        chk("t6_tvalid", 64'(m_tvalid), 64'd0);
        chk("t6_count", 64'(beat_count_o), 64'd0);
        chk("t6_busy", 64'(busy_o), 64'd0);
        chk("t6_wrap", 64'(wrap_o), 64'd0);
        reset_i = 1'b0;
        acc_cnt = 0; wrap_exp = 1'b0; stall_prev = 1'b0;
        tick();
        model_en = 1'b1;
        start(7, 1'b1);
        wait_valid(5);
`ifndef PATTERN_NOISE_EN
        chk("t6_restart", m_tdata, 64'h8000_7FF0_1230_ABC0);
`endif
        repeat (12) tick();
        stop_and_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
